// File: rtl/ra_bist_sdr_march.sv
// March C- / checkerboard / solid BIST engine and functional mux for an
// N-read/1-write SDR register array. Control and status use 0-is-MSB numbering.
module ra_bist_sdr_march #(
   parameter int AW       = 5,
   parameter int DW       = 32,
   parameter int RD_PORTS = 2,
   parameter int RD_LAT   = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [0:31]            ctl,
   output logic [0:31]            status,
   input  logic [RD_PORTS-1:0]    rd_enb_in,
   input  logic [RD_PORTS*AW-1:0] rd_adr_in,
   input  logic [RD_PORTS*DW-1:0] rd_dat,
   input  logic                   wr_enb_in,
   input  logic [AW-1:0]          wr_adr_in,
   input  logic [DW-1:0]          wr_dat_in,
   output logic [RD_PORTS-1:0]    rd_enb_out,
   output logic [RD_PORTS*AW-1:0] rd_adr_out,
   output logic                   wr_enb_out,
   output logic [AW-1:0]          wr_adr_out,
   output logic [DW-1:0]          wr_dat_out
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]    state;
   logic [2:0]    elem;
   logic          step;
   logic [AW-1:0] adr;
   logic [1:0]    mode_q;
   logic          stop_q;
   logic [15:0]   pat_q;
   logic [1:0]    dcnt;
   logic          fail_q;
   logic [1:0]    fport_q;
   logic [7:0]    fcnt_q;
   logic [AW-1:0] fadr_q;

   logic [DW-1:0] pd [RD_LAT];
   logic [AW-1:0] pa [RD_LAT];
   logic [RD_LAT-1:0] pv;

   logic          op_rd, op_inv, two_step, down, nxt_down, last_elem;
   logic [DW-1:0] op_dat;
   logic          eng_rd;
   logic          miss_any;
   logic [1:0]    miss_port;
   logic [AW-1:0] end_adr;
   logic [15:0]   fadr16;
   logic          unused_ctl;

   assign unused_ctl = ^ctl[4:15];

   // Decode the current element/step into the operation, its data and direction
   always_comb begin
      op_rd     = 1'b0;
      op_inv    = 1'b0;
      two_step  = 1'b0;
      down      = 1'b0;
      nxt_down  = 1'b0;
      last_elem = 1'b0;
      case (mode_q)
         2'b00: begin
            two_step  = (elem >= 3'd1) && (elem <= 3'd4);
            op_rd     = (elem == 3'd5) || (two_step && !step);
            // reads in elements 2 and 4 expect ~D0; the paired write flips it
            op_inv    = op_rd ? (elem == 3'd2 || elem == 3'd4)
                              : (elem != 3'd0) && !(elem == 3'd2 || elem == 3'd4);
            down      = (elem == 3'd3) || (elem == 3'd4);
            nxt_down  = (elem == 3'd2) || (elem == 3'd3);
            last_elem = (elem == 3'd5);
         end
         2'b01: begin
            op_rd     = elem[0];
            op_inv    = adr[0] ^ elem[1];
            last_elem = (elem == 3'd3);
         end
         default: begin
            op_rd     = elem[0];
            last_elem = (elem == 3'd1);
         end
      endcase
      op_dat  = {(DW/16){pat_q}} ^ {DW{op_inv}};
      end_adr = down ? '0 : '1;
      eng_rd  = (state == S_RUN) && op_rd;
   end

   // Compare the oldest pending read against its expected data, lowest port wins
   always_comb begin
      miss_any  = 1'b0;
      miss_port = 2'd0;
      if (pv[RD_LAT-1] && (state == S_RUN || state == S_DRAIN)) begin
         for (int unsigned i = 0; i < RD_PORTS; i++) begin
            if (rd_dat[i*DW +: DW] != pd[RD_LAT-1]) begin
               miss_any  = 1'b1;
               miss_port = 2'(RD_PORTS - 1 - i);
            end
         end
      end
   end

   // Array mux: passthrough when idle/done, engine in RUN, quiet in DRAIN
   always_comb begin
      rd_enb_out = '0;
      rd_adr_out = '0;
      wr_enb_out = 1'b0;
      wr_adr_out = '0;
      wr_dat_out = '0;
      if (state == S_IDLE || state == S_DONE) begin
         rd_enb_out = rd_enb_in;
         rd_adr_out = rd_adr_in;
         wr_enb_out = wr_enb_in;
         wr_adr_out = wr_adr_in;
         wr_dat_out = wr_dat_in;
      end else if (state == S_RUN) begin
         if (op_rd) begin
            rd_enb_out = '1;
            rd_adr_out = {RD_PORTS{adr}};
         end else begin
            wr_enb_out = 1'b1;
            wr_adr_out = adr;
            wr_dat_out = op_dat;
         end
      end
   end

   // Status word assembly
   always_comb begin
      fadr16       = 16'(fadr_q);
      status       = '0;
      status[0]    = (state == S_RUN) || (state == S_DRAIN);
      status[1]    = (state == S_DONE);
      status[2]    = fail_q;
      status[3:4]  = fport_q;
      status[8:15] = fcnt_q;
      status[16:31] = fadr16;
   end

   // Expected data/address/valid delay line matching the array read latency
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pv <= '0;
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            pd[i] <= '0;
            pa[i] <= '0;
         end
      end else if (state == S_IDLE || state == S_DONE) begin
         pv <= '0;
      end else begin
         pv[0] <= eng_rd;
         pd[0] <= op_dat;
         pa[0] <= adr;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
            pa[i] <= pa[i-1];
         end
      end
   end

   // Sequencer FSM with fail capture
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         elem    <= '0;
         step    <= 1'b0;
         adr     <= '0;
         mode_q  <= '0;
         stop_q  <= 1'b0;
         pat_q   <= '0;
         dcnt    <= '0;
         fail_q  <= 1'b0;
         fport_q <= '0;
         fcnt_q  <= '0;
         fadr_q  <= '0;
      end else begin
         if (miss_any) begin
            if (!fail_q) begin
               fail_q  <= 1'b1;
               fport_q <= miss_port;
               fadr_q  <= pa[RD_LAT-1];
            end
            if (fcnt_q != 8'hff) fcnt_q <= fcnt_q + 8'd1;
         end
         case (state)
            S_IDLE: begin
               if (ctl[0]) begin
                  state   <= S_RUN;
                  elem    <= '0;
                  step    <= 1'b0;
                  adr     <= '0;
                  mode_q  <= ctl[1:2];
                  stop_q  <= ctl[3];
                  pat_q   <= ctl[16:31];
                  fail_q  <= 1'b0;
                  fport_q <= '0;
                  fcnt_q  <= '0;
                  fadr_q  <= '0;
               end
            end
            S_RUN: begin
               if (!ctl[0]) begin
                  state <= S_IDLE;
               end else if (stop_q && miss_any) begin
                  state <= S_DRAIN;
                  dcnt  <= '0;
               end else if (two_step && !step) begin
                  step <= 1'b1;
               end else begin
                  step <= 1'b0;
                  if (adr == end_adr) begin
                     if (last_elem) begin
                        state <= S_DRAIN;
                        dcnt  <= '0;
                     end else begin
                        // next element starts from its own end, not the wrap value
                        elem <= elem + 3'd1;
                        adr  <= nxt_down ? '1 : '0;
                     end
                  end else begin
                     adr <= down ? adr - AW'(1) : adr + AW'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (!ctl[0])                   state <= S_IDLE;
               else if (dcnt == 2'(RD_LAT-1)) state <= S_DONE;
               else                           dcnt  <= dcnt + 2'd1;
            end
            default: begin
               if (!ctl[0]) state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ra_bist_sdr_march.sv
// Bench for ra_bist_sdr_march: RD_LAT=1 and RD_LAT=2 instances, behavioural
// array with fault injection, and an operation-list reference model.
module tb_ra_bist_sdr_march;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NP = 2;
   localparam int N  = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic [0:31] ctl_a, ctl_b, status_a, status_b;
   logic [NP-1:0]    rd_enb_in;
   logic [NP*AW-1:0] rd_adr_in;
   logic             wr_enb_in;
   logic [AW-1:0]    wr_adr_in;
   logic [DW-1:0]    wr_dat_in;
   logic [NP-1:0]    ren_a, ren_b;
   logic [NP*AW-1:0] radr_a, radr_b;
   logic             wen_a, wen_b;
   logic [AW-1:0]    wadr_a, wadr_b;
   logic [DW-1:0]    wdat_a, wdat_b;
   logic [NP*DW-1:0] rdat_a, rdat_b;

   int checks = 0;
   int failures = 0;

   // fault injection, per instance
   int f_en[2], f_adr[2], f_bit[2], p1_en[2], p1_adr[2];

   ra_bist_sdr_march #(.AW(AW), .DW(DW), .RD_PORTS(NP), .RD_LAT(1)) u_lat1 (
      .clk(clk), .reset(reset), .ctl(ctl_a), .status(status_a),
      .rd_enb_in(rd_enb_in), .rd_adr_in(rd_adr_in), .rd_dat(rdat_a),
      .wr_enb_in(wr_enb_in), .wr_adr_in(wr_adr_in), .wr_dat_in(wr_dat_in),
      .rd_enb_out(ren_a), .rd_adr_out(radr_a), .wr_enb_out(wen_a),
      .wr_adr_out(wadr_a), .wr_dat_out(wdat_a));

   ra_bist_sdr_march #(.AW(AW), .DW(DW), .RD_PORTS(NP), .RD_LAT(2)) u_lat2 (
      .clk(clk), .reset(reset), .ctl(ctl_b), .status(status_b),
      .rd_enb_in(rd_enb_in), .rd_adr_in(rd_adr_in), .rd_dat(rdat_b),
      .wr_enb_in(wr_enb_in), .wr_adr_in(wr_adr_in), .wr_dat_in(wr_dat_in),
      .rd_enb_out(ren_b), .rd_adr_out(radr_b), .wr_enb_out(wen_b),
      .wr_adr_out(wadr_b), .wr_dat_out(wdat_b));

   // ---------------- behavioural array ----------------
   logic [31:0] mem_a [N];
   logic [31:0] mem_b [N];
   logic [63:0] pipe_a, pipe_b0, pipe_b1;

   function automatic logic [31:0] faulty(int k, int p, int a, logic [31:0] w);
      logic [31:0] r = w;
      if (f_en[k] != 0 && a == f_adr[k]) r = r | (32'd1 << f_bit[k]);
      if (p1_en[k] != 0 && p == 1 && a == p1_adr[k]) r = r ^ 32'd1;
      return r;
   endfunction

   always @(posedge clk) begin
      if (wen_a) mem_a[wadr_a] <= wdat_a;
      if (wen_b) mem_b[wadr_b] <= wdat_b;
      pipe_a  <= {faulty(0, 0, int'(radr_a[9:5]), mem_a[radr_a[9:5]]),
                  faulty(0, 1, int'(radr_a[4:0]), mem_a[radr_a[4:0]])};
      pipe_b0 <= {faulty(1, 0, int'(radr_b[9:5]), mem_b[radr_b[9:5]]),
                  faulty(1, 1, int'(radr_b[4:0]), mem_b[radr_b[4:0]])};
      pipe_b1 <= pipe_b0;
   end
   assign rdat_a = pipe_a;
   assign rdat_b = pipe_b1;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [0:31] mk(bit busy, bit done, bit fail, int port, int cnt, int adr);
      logic [0:31] s;
      s = '0;
      s[0] = busy;
      s[1] = done;
      s[2] = fail;
      s[3:4] = 2'(port);
      s[8:15] = 8'(cnt);
      s[16:31] = 16'(adr);
      return s;
   endfunction

   // ---------------- reference model ----------------
   bit          q_wr[$];
   int          q_adr[$];
   logic [31:0] q_dat[$];

   task automatic push(bit w, int a, logic [31:0] d);
      q_wr.push_back(w);
      q_adr.push_back(a);
      q_dat.push_back(d);
   endtask

   task automatic build_ops(int mode, logic [15:0] p);
      logic [31:0] d0, cb;
      d0 = {p, p};
      q_wr.delete(); q_adr.delete(); q_dat.delete();
      if (mode == 0) begin
         for (int a = 0; a < N; a++) push(1, a, d0);
         for (int a = 0; a < N; a++) begin push(0, a, d0);  push(1, a, ~d0); end
         for (int a = 0; a < N; a++) begin push(0, a, ~d0); push(1, a, d0);  end
         for (int a = N-1; a >= 0; a--) begin push(0, a, d0);  push(1, a, ~d0); end
         for (int a = N-1; a >= 0; a--) begin push(0, a, ~d0); push(1, a, d0);  end
         for (int a = 0; a < N; a++) push(0, a, d0);
      end else if (mode == 1) begin
         for (int pass = 0; pass < 2; pass++) begin
            for (int a = 0; a < N; a++) begin
               cb = ((a % 2) != pass) ? ~d0 : d0;
               push(1, a, cb);
            end
            for (int a = 0; a < N; a++) begin
               cb = ((a % 2) != pass) ? ~d0 : d0;
               push(0, a, cb);
            end
         end
      end else begin
         for (int a = 0; a < N; a++) push(1, a, d0);
         for (int a = 0; a < N; a++) push(0, a, d0);
      end
   endtask

   // plays the op list against a word array; reads at index >= read_lim are never compared
   task automatic eval_model(input int k, input bit stop, input int read_lim,
                             output bit fail, output int port, output int cnt,
                             output int fadr, output int run_len);
      logic [31:0] m [N];
      int lat = k + 1;
      bit any;
      int fp;
      fail = 0; port = 0; cnt = 0; fadr = 0;
      run_len = q_wr.size();
      for (int i = 0; i < run_len; i++) begin
         if (q_wr[i]) m[q_adr[i]] = q_dat[i];
         else if (i < read_lim) begin
            any = 0; fp = 0;
            for (int p = NP-1; p >= 0; p--) begin
               if (faulty(k, p, q_adr[i], m[q_adr[i]]) != q_dat[i]) begin
                  any = 1; fp = p;
               end
            end
            if (any) begin
               if (cnt < 255) cnt++;
               if (!fail) begin
                  fail = 1; port = fp; fadr = q_adr[i];
                  if (stop && i + lat + 1 < run_len) run_len = i + lat + 1;
               end
            end
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic rnd_in();
      rd_enb_in = NP'($urandom);
      rd_adr_in = (NP*AW)'($urandom);
      wr_enb_in = 1'($urandom);
      wr_adr_in = AW'($urandom);
      wr_dat_in = $urandom;
   endtask

   task automatic chk_pass(string tag, int k);
      logic [49:0] o, e;
      e = {rd_enb_in, rd_adr_in, wr_enb_in, wr_adr_in, wr_dat_in};
      o = k ? {ren_b, radr_b, wen_b, wadr_b, wdat_b} : {ren_a, radr_a, wen_a, wadr_a, wdat_a};
      check(tag, o, e);
   endtask

   task automatic set_ctl(int k, logic [0:31] c);
      if (k != 0) ctl_b = c; else ctl_a = c;
   endtask

   logic [31:0] w0_obs, w1_obs;

   // Must be called at a negedge; start is sampled at the following posedge.
   task automatic run(input int k, input int mode, input logic [15:0] p,
                      input bit stop, input int abort_at);
      logic [0:31] c, s, s_done;
      bit fail, seen0, seen1;
      int port, cnt, fadr, run_len, lat, errs, done_at, rlim;
      bit ok, en_w;
      logic [1:0] en_r;
      logic [9:0] ra;
      logic [4:0] wa;
      logic [31:0] wd;
      lat = k + 1;
      build_ops(mode, p);
      rlim = (abort_at >= 0) ? abort_at - lat + 1 : 1 << 30;
      eval_model(k, stop, rlim, fail, port, cnt, fadr, run_len);
      c = '0; c[0] = 1'b1; c[1:2] = 2'(mode); c[3] = stop; c[16:31] = p;
      set_ctl(k, c);
      @(posedge clk);
      errs = 0; done_at = -1; seen0 = 0; seen1 = 0; s_done = '0;
      for (int cyc = 0; cyc < 700 && done_at < 0; cyc++) begin
         @(negedge clk);
         s    = k ? status_b : status_a;
         en_r = k ? ren_b  : ren_a;
         ra   = k ? radr_b : radr_a;
         en_w = k ? wen_b  : wen_a;
         wa   = k ? wadr_b : wadr_a;
         wd   = k ? wdat_b : wdat_a;
         if (abort_at >= 0 && cyc == abort_at + 1) begin
            check("abort_status", s, mk(0, 0, fail, port, cnt, fadr));
            check("abort_ops", errs, 0);
            return;
         end
         if (s[1]) begin
            done_at = cyc;
            s_done = s;
         end else begin
            if (!s[0]) errs++;
            if (cyc < run_len) begin
               if (q_wr[cyc])
                  ok = en_w && en_r == 2'b00 && wa == 5'(q_adr[cyc]) && wd == q_dat[cyc];
               else
                  ok = !en_w && en_r == 2'b11 && ra == {5'(q_adr[cyc]), 5'(q_adr[cyc])};
               if (en_w && wa == 5'd0 && !seen0) begin w0_obs = wd; seen0 = 1; end
               if (en_w && wa == 5'd1 && !seen1) begin w1_obs = wd; seen1 = 1; end
            end else begin
               ok = !en_w && en_r == 2'b00;
            end
            if (!ok) errs++;
            if (abort_at >= 0 && cyc == abort_at) c[0] = 1'b0;
            set_ctl(k, c);
         end
         rnd_in();
      end
      check("run_ops", errs, 0);
      check("done_cycle", done_at, run_len + lat);
      check("done_status", s_done, mk(0, 1, fail, port, cnt, fadr));
      rnd_in();
      #1 chk_pass("pass_done", k);
      @(negedge clk);
      c[0] = 1'b0;
      set_ctl(k, c);
      @(negedge clk);
      check("idle_status", k ? status_b : status_a, mk(0, 0, fail, port, cnt, fadr));
   endtask

   task automatic clr_faults();
      for (int k = 0; k < 2; k++) begin
         f_en[k] = 0; f_adr[k] = 0; f_bit[k] = 0; p1_en[k] = 0; p1_adr[k] = 0;
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      clr_faults();
      reset = 1'b0;
      ctl_a = '0; ctl_b = '0;
      rd_enb_in = '0; rd_adr_in = '0; wr_enb_in = 1'b0; wr_adr_in = '0; wr_dat_in = '0;
      #1;
      check("reset_status_a", status_a, 32'h0);
      check("reset_status_b", status_b, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // idle passthrough
      for (int i = 0; i < 6; i++) begin
         rnd_in();
         #1 chk_pass("pass_idle_a", 0);
         chk_pass("pass_idle_b", 1);
         @(negedge clk);
      end

      // clean March C-, then stuck-at-1 bit 5 word 7, then with stop-on-fail
      run(0, 0, 16'h0000, 0, -1);
      f_en[0] = 1; f_adr[0] = 7; f_bit[0] = 5;
      run(0, 0, 16'h0000, 0, -1);
      run(0, 0, 16'h0000, 1, -1);
      clr_faults();

      // checkerboard on the RD_LAT=2 instance, then port 1 corrupted at the top word
      run(1, 1, 16'h5555, 0, -1);
      check("cb_word0", w0_obs, 32'h5555_5555);
      check("cb_word1", w1_obs, 32'hAAAA_AAAA);
      p1_en[1] = 1; p1_adr[1] = 31;
      run(1, 1, 16'h5555, 0, -1);
      clr_faults();

      // abort mid-run retains fail capture
      f_en[0] = 1; f_adr[0] = 2; f_bit[0] = 9;
      run(0, 0, 16'h1234, 0, 60);
      clr_faults();
      @(negedge clk);

      // asynchronous reset in the middle of a March run
      begin
         logic [0:31] c;
         c = '0; c[0] = 1'b1;
         ctl_a = c;
         repeat (100) @(negedge clk);
         rd_enb_in = '0; wr_enb_in = 1'b0;
         #2 reset = 1'b0;
         #1;
         check("arst_status", status_a, 32'h0);
         check("arst_enables", {ren_a, wen_a}, 3'b000);
         @(negedge clk);
         reset = 1'b1;
         run(0, 0, 16'h0000, 0, -1);
      end

      // randomized runs
      for (int i = 0; i < 10; i++) begin
         int k, mode;
         clr_faults();
         k = int'($urandom_range(0, 1));
         mode = int'($urandom_range(0, 3));
         if ($urandom_range(0, 1) != 0) begin
            f_en[k] = 1; f_adr[k] = int'($urandom_range(0, N-1)); f_bit[k] = int'($urandom_range(0, 31));
         end
         if ($urandom_range(0, 3) == 0) begin
            p1_en[k] = 1; p1_adr[k] = int'($urandom_range(0, N-1));
         end
         run(k, mode, 16'($urandom), 1'($urandom), -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ra_bist_sdr_march.md
Name: ra_bist_sdr_march

Overview:
- Parametrised successor to the fixed 32x32 SDR BIST/mux block.
- Sits between the functional port logic and an N-read/1-write SDR register array (ra_2r1w_* family), inside test_ra_* wrappers.
- Passes functional traffic through when idle. When started, runs a selectable algorithm (March C-, checkerboard, solid pattern) over the whole array and compares every read port.
- Reports busy/done/fail, a saturating fail count and first-fail location.

Parameters:
- AW, 5: address width; depth N = 2^AW words (AW <= 16).
- DW, 32: data width; must be a multiple of 16.
- RD_PORTS, 2: number of read ports (1..4).
- RD_LAT, 1: cycles from read enable/address to valid read data (1..3).

Ports:
- clk  in  1: array clock.
- reset  in  1: asynchronous, active-low reset.
- ctl  in  32: control. [0] start/run level; [1:2] mode (00 March C-, 01 checkerboard, 10 solid, 11 reserved = solid); [3] stop-on-fail; [16:31] background pattern P.
- status  out  32: [0] busy; [1] done; [2] fail; [3:4] first-fail port; [5:7] 0; [8:15] fail count; [16:31] first-fail address, zero-extended.
- rd_enb_in  in  RD_PORTS: functional read enables.
- rd_adr_in  in  RD_PORTS*AW: functional read addresses, port 0 in MSBs.
- rd_dat  in  RD_PORTS*DW: array read data, for compare.
- wr_enb_in  in  1: functional write enable.
- wr_adr_in  in  AW: functional write address.
- wr_dat_in  in  DW: functional write data.
- rd_enb_out  out  RD_PORTS: to array.
- rd_adr_out  out  RD_PORTS*AW: to array.
- wr_enb_out  out  1: to array.
- wr_adr_out  out  AW: to array.
- wr_dat_out  out  DW: to array.

Behaviour:
- Reset (reset=0, async):
  - FSM goes to IDLE; status = 0.
  - Address counter, compare pipeline and fail capture are cleared.
  - Outputs follow IDLE passthrough.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: array outputs are a combinational passthrough of the *_in ports. If ctl[0]=1 at a clock edge, go to RUN; that edge clears fail, count, first-fail fields and sets busy.
  - RUN: the engine drives the array and all *_in ports are ignored. One operation per cycle; element/step sequencing is below.
  - DRAIN: RD_LAT cycles with all enables 0, letting pending compares retire. Then go to DONE (busy=0, done=1).
  - DONE: outputs are passthrough; status is held. Go to IDLE when ctl[0]=0, which clears done; fail, count and address are held.
  - ctl[0]=0 during RUN or DRAIN aborts immediately to IDLE: busy=0, done=0, fail fields retained.
- Data backgrounds:
  - D0 = P replicated to DW.
  - March and solid use D0 and ~D0.
  - Checkerboard: word a uses D0 when a is even and ~D0 when a is odd; the second pass inverts.
- Algorithms (^ = ascending 0..N-1, v = descending N-1..0; each r/w is one cycle):
  - March C-: ^(w0); ^(r0,w1); ^(r1,w0); v(r0,w1); v(r1,w0); ^(r0). Total 10N cycles.
  - Checkerboard: ^(w CB); ^(r CB); ^(w ~CB); ^(r ~CB). Total 4N cycles.
  - Solid: ^(w D0); ^(r D0). Total 2N cycles.
- Engine port usage:
  - Reads assert all RD_PORTS enables with the same address.
  - Writes use wr_*_out only.
  - A read and a write are never issued in the same cycle.
- Address counter:
  - Wraps N-1 -> 0 (ascending) or 0 -> N-1 (descending) at element end.
  - Element index advances on the wrap.
  - After the last element's final op, go to DRAIN.
- Compare:
  - Expected data, address and a valid bit are delayed RD_LAT cycles.
  - On valid, each port's rd_dat is compared with expected.
  - Any mismatch sets fail; count increments by 1 per failing cycle (not per port), saturating at 255.
  - On the first failure only, capture the address and the lowest-numbered failing port.
- Stop-on-fail: with ctl[3]=1, the first mismatch moves RUN -> DRAIN on the next edge (remaining pending compares still counted), then DONE.
- Timing: with start sampled at edge E0, done=1 after edge E0 + cycles(mode) + RD_LAT.

Test Plan:
- AW=5, DW=32, RD_PORTS=2, RD_LAT=1, fault-free array model, ctl=0x0000_0001 then held -> busy for 321 cycles, then status = 0x4000_0000 (done only); drop start -> status = 0.
- Stuck-at-1 on bit 5 of word 7 in the array model, March C-, P=0x0000 -> done=1, fail=1, first addr=7, port=0, count=3 (r0 reads in elements 2, 4, 6).
- Same fault with ctl[3]=1 -> DONE reached within 2+RD_LAT cycles of the first miscompare; count=1; addr=7.
- Checkerboard, P=0x5555, RD_LAT=2 -> word 0 written 0x5555_5555, word 1 written 0xAAAA_AAAA, done after 130 cycles, no fail; read port 1 forced wrong at addr 31 -> port field=1, addr=31.
- Idle passthrough: random functional reads and writes -> *_out equal *_in in the same cycle. During RUN, functional writes never reach wr_enb_out.
- Assert reset at cycle 100 of a March run -> status=0 and enables 0 immediately (asynchronously), FSM in IDLE. With ctl[0] still 1 after release, a new run starts and completes clean.
